angle_servo_ctrl: RTL and testbench

//  Parametrised closed-loop steering controller, successor to the fixed 12-bit angle-to-PWM path.

---
 rtl/angle_servo_ctrl_if.sv | 30 +++
 rtl/angle_servo_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_angle_servo_ctrl.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/angle_servo_ctrl_if.sv
// Bundle of the command, encoder and PWM handshake signals of the steering controller.
// The controller connects through the slave modport; the register side / bench drives the master side.
interface angle_servo_ctrl_if #(
    parameter int ANGLE_W = 12,
    parameter int PWM_W   = 8
);
    logic [ANGLE_W-1:0] target_angle;
    logic               angle_update;
    logic               abort;
    logic [ANGLE_W-1:0] current_angle;
    logic               angle_valid;
    logic               angle_done;
    logic               busy;
    logic               timeout_err;
    logic               pwm_enable;
    logic [PWM_W-1:0]   pwm_ratio;
    logic               pwm_direction;
    logic               pwm_update;
    logic               pwm_done;

    modport slave (
        input  target_angle, angle_update, abort, current_angle, angle_valid, pwm_done,
        output angle_done, busy, timeout_err, pwm_enable, pwm_ratio, pwm_direction, pwm_update
    );

    modport master (
        output target_angle, angle_update, abort, current_angle, angle_valid, pwm_done,
        input  angle_done, busy, timeout_err, pwm_enable, pwm_ratio, pwm_direction, pwm_update
    );
endinterface

// File: rtl/angle_servo_ctrl.sv
// Closed-loop steering controller: compares a latched target with encoder samples and
// issues ramp-limited, shortest-path PWM drive commands until the angle settles in the deadband.
module angle_servo_ctrl #(
    parameter int ANGLE_W   = 12,
    parameter int PWM_W     = 8,
    parameter int DEADBAND  = 4,
    parameter int SETTLE_N  = 3,
    parameter int KP_SHIFT  = 2,
    parameter int MIN_RATIO = 20,
    parameter int MAX_RATIO = 200,
    parameter int RAMP_STEP = 8,
    parameter int TIMEOUT_W = 24
) (
    input  logic              clock,
    input  logic              reset_n,
    angle_servo_ctrl_if.slave bus
);
    localparam int SETTLE_W = $clog2(SETTLE_N + 1);

    localparam logic [ANGLE_W-1:0]   HALF_A   = {1'b1, {(ANGLE_W-1){1'b0}}};
    localparam logic [ANGLE_W-1:0]   DB_A     = ANGLE_W'(DEADBAND);
    localparam logic [ANGLE_W-1:0]   MIN_A    = ANGLE_W'(MIN_RATIO);
    localparam logic [ANGLE_W-1:0]   MAX_A    = ANGLE_W'(MAX_RATIO);
    localparam logic [PWM_W-1:0]     MIN_R    = PWM_W'(MIN_RATIO);
    localparam logic [PWM_W-1:0]     MAX_R    = PWM_W'(MAX_RATIO);
    localparam logic [PWM_W:0]       STEP_R   = (PWM_W+1)'(RAMP_STEP);
    localparam logic [SETTLE_W-1:0]  SETTLE_T = SETTLE_W'(SETTLE_N);
    localparam logic [TIMEOUT_W-1:0] TO_MAX   = {TIMEOUT_W{1'b1}};

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_S   = 3'd1,
        ST_CALC     = 3'd2,
        ST_REQ      = 3'd3,
        ST_WAIT_ACK = 3'd4
    } state_t;

    state_t               state_r;
    logic [ANGLE_W-1:0]   target_r;
    logic [ANGLE_W-1:0]   current_r;
    logic [PWM_W-1:0]     last_r;
    logic [SETTLE_W-1:0]  settle_r;
    logic [TIMEOUT_W-1:0] timeout_r;
    logic                 angle_done_r;
    logic                 busy_r;
    logic                 timeout_err_r;
    logic                 pwm_enable_r;
    logic [PWM_W-1:0]     pwm_ratio_r;
    logic                 pwm_direction_r;
    logic                 pwm_update_r;

    logic [ANGLE_W-1:0]   diff_s;
    logic [ANGLE_W-1:0]   mag_s;
    logic                 dir_s;
    logic [ANGLE_W-1:0]   shifted_s;
    logic [PWM_W-1:0]     raw_s;
    logic [PWM_W-1:0]     last_eff_s;
    logic [PWM_W:0]       ramp_lim_s;
    logic [PWM_W-1:0]     drive_ratio_s;
    logic                 in_band_s;
    logic [SETTLE_W-1:0]  settle_inc_s;

    assign bus.angle_done    = angle_done_r;
    assign bus.busy          = busy_r;
    assign bus.timeout_err   = timeout_err_r;
    assign bus.pwm_enable    = pwm_enable_r;
    assign bus.pwm_ratio     = pwm_ratio_r;
    assign bus.pwm_direction = pwm_direction_r;
    assign bus.pwm_update    = pwm_update_r;

    // Shortest-path error, proportional ratio with clamp, and ramp limit on increases.
    always_comb begin
        diff_s = target_r - current_r;
        // Exactly half a circle resolves to the CW direction.
        if (diff_s <= HALF_A) begin
            dir_s = 1'b1;
            mag_s = diff_s;
        end else begin
            dir_s = 1'b0;
            mag_s = {ANGLE_W{1'b0}} - diff_s;
        end
        shifted_s = mag_s >> KP_SHIFT;
        if (shifted_s > MAX_A) begin
            raw_s = MAX_R;
        end else if (shifted_s < MIN_A) begin
            raw_s = MIN_R;
        end else begin
            raw_s = shifted_s[PWM_W-1:0];
        end
        // A reversal restarts the ramp from zero so the motor is never slammed backwards.
        if (dir_s != pwm_direction_r) begin
            last_eff_s = {PWM_W{1'b0}};
        end else begin
            last_eff_s = last_r;
        end
        ramp_lim_s = {1'b0, last_eff_s} + STEP_R;
        if ({1'b0, raw_s} > ramp_lim_s) begin
            drive_ratio_s = ramp_lim_s[PWM_W-1:0];
        end else begin
            drive_ratio_s = raw_s;
        end
        in_band_s    = (mag_s <= DB_A);
        settle_inc_s = settle_r + SETTLE_W'(1);
    end

    // Control FSM with registered outputs; abort and timeout override everything else.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r         <= ST_IDLE;
            target_r        <= {ANGLE_W{1'b0}};
            current_r       <= {ANGLE_W{1'b0}};
            last_r          <= {PWM_W{1'b0}};
            settle_r        <= {SETTLE_W{1'b0}};
            timeout_r       <= {TIMEOUT_W{1'b0}};
            angle_done_r    <= 1'b0;
            busy_r          <= 1'b0;
            timeout_err_r   <= 1'b0;
            pwm_enable_r    <= 1'b0;
            pwm_ratio_r     <= {PWM_W{1'b0}};
            pwm_direction_r <= 1'b0;
            pwm_update_r    <= 1'b0;
        end else begin
            angle_done_r <= 1'b0;
            if (bus.abort || (busy_r && (timeout_r == TO_MAX))) begin
                // Abort and timeout share the stop path; an outstanding pwm_done is dropped.
                state_r      <= ST_IDLE;
                busy_r       <= 1'b0;
                pwm_enable_r <= 1'b0;
                pwm_ratio_r  <= {PWM_W{1'b0}};
                pwm_update_r <= 1'b0;
                last_r       <= {PWM_W{1'b0}};
                settle_r     <= {SETTLE_W{1'b0}};
                timeout_r    <= {TIMEOUT_W{1'b0}};
                if (!bus.abort) begin
                    timeout_err_r <= 1'b1;
                end
            end else begin
                if (busy_r) begin
                    timeout_r <= timeout_r + TIMEOUT_W'(1);
                end
                case (state_r)
                    ST_IDLE: begin
                        if (bus.angle_update) begin
                            target_r      <= bus.target_angle;
                            busy_r        <= 1'b1;
                            timeout_err_r <= 1'b0;
                            settle_r      <= {SETTLE_W{1'b0}};
                            timeout_r     <= {TIMEOUT_W{1'b0}};
                            state_r       <= ST_WAIT_S;
                        end
                    end
                    ST_WAIT_S: begin
                        if (bus.angle_valid) begin
                            current_r <= bus.current_angle;
                            state_r   <= ST_CALC;
                        end
                    end
                    ST_CALC: begin
                        if (in_band_s) begin
                            if (settle_inc_s >= SETTLE_T) begin
                                settle_r     <= {SETTLE_W{1'b0}};
                                pwm_enable_r <= 1'b0;
                                pwm_ratio_r  <= {PWM_W{1'b0}};
                                last_r       <= {PWM_W{1'b0}};
                                angle_done_r <= 1'b1;
                                busy_r       <= 1'b0;
                                state_r      <= ST_IDLE;
                            end else begin
                                settle_r     <= settle_inc_s;
                                pwm_ratio_r  <= {PWM_W{1'b0}};
                                pwm_enable_r <= 1'b1;
                                pwm_update_r <= 1'b1;
                                state_r      <= ST_REQ;
                            end
                        end else begin
                            settle_r        <= {SETTLE_W{1'b0}};
                            pwm_ratio_r     <= drive_ratio_s;
                            pwm_direction_r <= dir_s;
                            pwm_enable_r    <= 1'b1;
                            pwm_update_r    <= 1'b1;
                            state_r         <= ST_REQ;
                        end
                    end
                    ST_REQ: begin
                        pwm_update_r <= 1'b0;
                        if (bus.pwm_done) begin
                            last_r  <= pwm_ratio_r;
                            state_r <= ST_WAIT_S;
                        end else begin
                            state_r <= ST_WAIT_ACK;
                        end
                    end
                    ST_WAIT_ACK: begin
                        if (bus.pwm_done) begin
                            last_r  <= pwm_ratio_r;
                            state_r <= ST_WAIT_S;
                        end
                    end
                    default: begin
                        state_r <= ST_IDLE;
                    end
                endcase
                // A new request while busy retargets without disturbing the handshake.
                if (bus.angle_update && busy_r) begin
                    target_r  <= bus.target_angle;
                    settle_r  <= {SETTLE_W{1'b0}};
                    timeout_r <= {TIMEOUT_W{1'b0}};
                end
            end
        end
    end
endmodule

// File: tb/tb_angle_servo_ctrl.sv
// Directed bench for angle_servo_ctrl: one task per scenario, hand-computed expectations.
module tb_angle_servo_ctrl;
    logic clock;
    logic reset_n;
    int   tests_run;
    int   tests_failed;

    angle_servo_ctrl_if #(.ANGLE_W(12), .PWM_W(8)) bus ();
    angle_servo_ctrl_if #(.ANGLE_W(12), .PWM_W(8)) bus2 ();

    angle_servo_ctrl dut (.clock(clock), .reset_n(reset_n), .bus(bus));
    angle_servo_ctrl #(.TIMEOUT_W(4)) dut_to (.clock(clock), .reset_n(reset_n), .bus(bus2));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic start_move(input logic [11:0] tgt);
        bus.target_angle = tgt;
        bus.angle_update = 1'b1;
        step();
        bus.angle_update = 1'b0;
    endtask

    task automatic do_abort();
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
    endtask

    // Drives one encoder sample and returns {pwm_update, pwm_enable, pwm_direction, angle_done, busy, pwm_ratio}
    // observed two cycles after the strobe; acknowledges any update after ack_delay cycles.
    task automatic send_sample(input logic [11:0] ang, input int ack_delay, output logic [12:0] obs);
        bus.current_angle = ang;
        bus.angle_valid   = 1'b1;
        step();
        bus.angle_valid   = 1'b0;
        step();
        obs = {bus.pwm_update, bus.pwm_enable, bus.pwm_direction, bus.angle_done, bus.busy, bus.pwm_ratio};
        if (bus.pwm_update) begin
            repeat (ack_delay) step();
            bus.pwm_done = 1'b1;
            step();
            bus.pwm_done = 1'b0;
        end
    endtask

    task automatic test_reset();
        logic [13:0] o1, o2;
        reset_n = 1'b0;
        #12;
        o1 = {bus.angle_done, bus.busy, bus.timeout_err, bus.pwm_enable, bus.pwm_ratio, bus.pwm_direction, bus.pwm_update};
        tests_run++;
        if (o1 !== 14'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %h expected %h", o1, 14'd0);
        end
        reset_n = 1'b1;
        step();
        o2 = {bus2.angle_done, bus2.busy, bus2.timeout_err, bus2.pwm_enable, bus2.pwm_ratio, bus2.pwm_direction, bus2.pwm_update};
        tests_run++;
        if (o2 !== 14'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs_dut2: got %h expected %h", o2, 14'd0);
        end
    endtask

    task automatic test_settle();
        logic [12:0] obs;
        logic [12:0] exp_v [5];
        logic [11:0] ang   [5];
        ang[0] = 12'd0;   exp_v[0] = {1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'd8};
        ang[1] = 12'd50;  exp_v[1] = {1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'd16};
        ang[2] = 12'd98;  exp_v[2] = {1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'd0};
        ang[3] = 12'd99;  exp_v[3] = {1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'd0};
        ang[4] = 12'd100; exp_v[4] = {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0};
        start_move(12'd100);
        tests_run++;
        if (bus.busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL settle_busy_on_accept: got %b expected 1", bus.busy);
        end
        for (int i = 0; i < 5; i++) begin
            send_sample(ang[i], 1, obs);
            tests_run++;
            if (obs !== exp_v[i]) begin
                tests_failed++;
                $display("FAIL settle_sample%0d: got %h expected %h", i, obs, exp_v[i]);
            end
        end
        step();
        tests_run++;
        if (bus.angle_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL settle_done_pulse: got %b expected 0", bus.angle_done);
        end
    endtask

    task automatic test_wrap();
        logic [12:0] obs;
        logic [11:0] tgt   [4];
        logic [11:0] cur   [4];
        logic [12:0] exp_v [4];
        tgt[0] = 12'd10;   cur[0] = 12'd4090; exp_v[0] = {1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'd8};
        tgt[1] = 12'd4090; cur[1] = 12'd10;   exp_v[1] = {1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'd8};
        tgt[2] = 12'd2048; cur[2] = 12'd0;    exp_v[2] = {1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'd8};
        tgt[3] = 12'd2049; cur[3] = 12'd0;    exp_v[3] = {1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'd8};
        for (int i = 0; i < 4; i++) begin
            start_move(tgt[i]);
            send_sample(cur[i], 0, obs);
            tests_run++;
            if (obs !== exp_v[i]) begin
                tests_failed++;
                $display("FAIL wrap_case%0d: got %h expected %h", i, obs, exp_v[i]);
            end
            do_abort();
        end
    endtask

    task automatic test_ramp();
        logic [12:0] obs;
        logic [7:0]  exp_r;
        start_move(12'd2000);
        for (int k = 1; k <= 26; k++) begin
            exp_r = (k * 8 > 200) ? 8'd200 : 8'(k * 8);
            send_sample(12'd0, 0, obs);
            tests_run++;
            if (obs !== {1'b1, 1'b1, 1'b1, 1'b0, 1'b1, exp_r}) begin
                tests_failed++;
                $display("FAIL ramp_step%0d: got %h expected %h", k, obs, {1'b1, 1'b1, 1'b1, 1'b0, 1'b1, exp_r});
            end
        end
        // Retarget while busy: mag 40 -> 10, clamped up to MIN_RATIO, below the ramp limit.
        start_move(12'd40);
        send_sample(12'd0, 0, obs);
        tests_run++;
        if (obs !== {1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'd20}) begin
            tests_failed++;
            $display("FAIL ramp_min_ratio: got %h expected %h", obs, {1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'd20});
        end
        // Overshoot to 80 reverses direction: ramp restarts at RAMP_STEP.
        send_sample(12'd80, 0, obs);
        tests_run++;
        if (obs !== {1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'd8}) begin
            tests_failed++;
            $display("FAIL ramp_reversal: got %h expected %h", obs, {1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'd8});
        end
        do_abort();
    endtask

    task automatic test_abort();
        logic [11:0] o;
        start_move(12'd500);
        bus.current_angle = 12'd0;
        bus.angle_valid   = 1'b1;
        step();
        bus.angle_valid   = 1'b0;
        step();
        step();
        o = {bus.pwm_update, bus.pwm_enable, bus.busy, bus.angle_done, bus.pwm_ratio};
        tests_run++;
        if (o !== {1'b0, 1'b1, 1'b1, 1'b0, 8'd8}) begin
            tests_failed++;
            $display("FAIL abort_hold_in_wait_ack: got %h expected %h", o, {1'b0, 1'b1, 1'b1, 1'b0, 8'd8});
        end
        bus.abort    = 1'b1;
        bus.pwm_done = 1'b1;
        step();
        bus.abort    = 1'b0;
        bus.pwm_done = 1'b0;
        o = {bus.pwm_update, bus.pwm_enable, bus.busy, bus.angle_done, bus.pwm_ratio};
        tests_run++;
        if (o !== 12'd0) begin
            tests_failed++;
            $display("FAIL abort_stop: got %h expected %h", o, 12'd0);
        end
        step();
        tests_run++;
        if (bus.angle_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_no_done: got %b expected 0", bus.angle_done);
        end
        // A strobe while idle must not start anything.
        bus.angle_valid = 1'b1;
        step();
        bus.angle_valid = 1'b0;
        step();
        step();
        o = {bus.pwm_update, bus.pwm_enable, bus.busy, bus.angle_done, bus.pwm_ratio};
        tests_run++;
        if (o !== 12'd0) begin
            tests_failed++;
            $display("FAIL idle_ignores_valid: got %h expected %h", o, 12'd0);
        end
    endtask

    task automatic test_timeout();
        int cycles;
        bus2.target_angle = 12'd123;
        bus2.angle_update = 1'b1;
        step();
        bus2.angle_update = 1'b0;
        cycles = 0;
        while (bus2.busy === 1'b1 && cycles < 40) begin
            step();
            cycles++;
        end
        tests_run++;
        if (cycles !== 16) begin
            tests_failed++;
            $display("FAIL timeout_cycles: got %0d expected 16", cycles);
        end
        tests_run++;
        if ({bus2.timeout_err, bus2.busy, bus2.pwm_enable} !== 3'b100) begin
            tests_failed++;
            $display("FAIL timeout_flags: got %b expected 100", {bus2.timeout_err, bus2.busy, bus2.pwm_enable});
        end
        step();
        tests_run++;
        if (bus2.timeout_err !== 1'b1) begin
            tests_failed++;
            $display("FAIL timeout_sticky: got %b expected 1", bus2.timeout_err);
        end
        bus2.angle_update = 1'b1;
        step();
        bus2.angle_update = 1'b0;
        tests_run++;
        if ({bus2.timeout_err, bus2.busy} !== 2'b01) begin
            tests_failed++;
            $display("FAIL timeout_clear: got %b expected 01", {bus2.timeout_err, bus2.busy});
        end
        bus2.abort = 1'b1;
        step();
        bus2.abort = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [13:0] o;
        logic [12:0] obs;
        start_move(12'd300);
        bus.current_angle = 12'd0;
        bus.angle_valid   = 1'b1;
        step();
        bus.angle_valid   = 1'b0;
        step();
        step();
        #1;
        reset_n = 1'b0;
        #1;
        o = {bus.angle_done, bus.busy, bus.timeout_err, bus.pwm_enable, bus.pwm_ratio, bus.pwm_direction, bus.pwm_update};
        tests_run++;
        if (o !== 14'd0) begin
            tests_failed++;
            $display("FAIL reset_async: got %h expected %h", o, 14'd0);
        end
        #1;
        reset_n = 1'b1;
        step();
        start_move(12'd300);
        send_sample(12'd0, 0, obs);
        tests_run++;
        if (obs !== {1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'd8}) begin
            tests_failed++;
            $display("FAIL reset_recover: got %h expected %h", obs, {1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'd8});
        end
        do_abort();
    endtask

    initial begin
        tests_run          = 0;
        tests_failed       = 0;
        bus.target_angle   = 12'd0;
        bus.angle_update   = 1'b0;
        bus.abort          = 1'b0;
        bus.current_angle  = 12'd0;
        bus.angle_valid    = 1'b0;
        bus.pwm_done       = 1'b0;
        bus2.target_angle  = 12'd0;
        bus2.angle_update  = 1'b0;
        bus2.abort         = 1'b0;
        bus2.current_angle = 12'd0;
        bus2.angle_valid   = 1'b0;
        bus2.pwm_done      = 1'b0;
        test_reset();
        test_settle();
        test_wrap();
        test_ramp();
        test_abort();
        test_timeout();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
